// File: rtl/stage_pkg.sv
// Shared definitions for the stage sequencer: FSM states, stage codes,
// OLED source codes, 7-segment owner codes and state-to-code helpers.
// No ports (package). Optional build macro used elsewhere: RETRY_SCREEN_EN.
package stage_pkg;

   localparam int unsigned STAGE_W     = 4;
   localparam int unsigned DISP_W      = 4;
   localparam int unsigned SEG_W       = 2;
   localparam int unsigned TRANS_CNT_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TRANS0 = 3'd1,
      ST_GAME1  = 3'd2,
      ST_TRANS1 = 3'd3,
      ST_GAME2  = 3'd4,
      ST_GAME3  = 3'd5,
      ST_TRANS2 = 3'd6,
      ST_DECO   = 3'd7
   } fsm_e;

   // Stage codes seen by the game modules
   localparam logic [STAGE_W-1:0] STAGE_IDLE  = 4'd0;
   localparam logic [STAGE_W-1:0] STAGE_GAME1 = 4'd1;
   localparam logic [STAGE_W-1:0] STAGE_GAME2 = 4'd2;
   localparam logic [STAGE_W-1:0] STAGE_GAME3 = 4'd3;
   localparam logic [STAGE_W-1:0] STAGE_DECO  = 4'd8;

   // OLED source selects
   localparam logic [DISP_W-1:0] DISP_START  = 4'd0;
   localparam logic [DISP_W-1:0] DISP_TRANS0 = 4'd1;
   localparam logic [DISP_W-1:0] DISP_GAME1  = 4'd2;
   localparam logic [DISP_W-1:0] DISP_TRANS1 = 4'd3;
   localparam logic [DISP_W-1:0] DISP_GAME2  = 4'd4;
   localparam logic [DISP_W-1:0] DISP_GAME3  = 4'd5;
   localparam logic [DISP_W-1:0] DISP_RETRY  = 4'd6;
   localparam logic [DISP_W-1:0] DISP_TRANS2 = 4'd7;
   localparam logic [DISP_W-1:0] DISP_DECO   = 4'd8;

   // 7-segment owners
   localparam logic [SEG_W-1:0] SEG_BLANK = 2'd0;
   localparam logic [SEG_W-1:0] SEG_GAME2 = 2'd1;
   localparam logic [SEG_W-1:0] SEG_GAME3 = 2'd2;

   // Transition states share the idle stage code
   function automatic logic [STAGE_W-1:0] stage_code(input fsm_e s);
      logic [STAGE_W-1:0] code;
      code = STAGE_IDLE;
      case (s)
         ST_GAME1: code = STAGE_GAME1;
         ST_GAME2: code = STAGE_GAME2;
         ST_GAME3: code = STAGE_GAME3;
         ST_DECO:  code = STAGE_DECO;
         default:  code = STAGE_IDLE;
      endcase
      return code;
   endfunction

   // Base OLED source; the retry override is applied by the sequencer
   function automatic logic [DISP_W-1:0] disp_code(input fsm_e s);
      logic [DISP_W-1:0] code;
      code = DISP_START;
      case (s)
         ST_IDLE:   code = DISP_START;
         ST_TRANS0: code = DISP_TRANS0;
         ST_GAME1:  code = DISP_GAME1;
         ST_TRANS1: code = DISP_TRANS1;
         ST_GAME2:  code = DISP_GAME2;
         ST_GAME3:  code = DISP_GAME3;
         ST_TRANS2: code = DISP_TRANS2;
         ST_DECO:   code = DISP_DECO;
         default:   code = DISP_START;
      endcase
      return code;
   endfunction

   function automatic logic [SEG_W-1:0] seg_code(input fsm_e s);
      logic [SEG_W-1:0] code;
      code = SEG_BLANK;
      case (s)
         ST_GAME2: code = SEG_GAME2;
         ST_GAME3: code = SEG_GAME3;
         default:  code = SEG_BLANK;
      endcase
      return code;
   endfunction

   function automatic logic is_trans(input fsm_e s);
      return (s == ST_TRANS0) || (s == ST_TRANS1) || (s == ST_TRANS2);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Start-button conditioner: 2-flop synchronizer followed by a debouncer that
// accepts a new level only after DEBOUNCE_CYCLES consecutive identical
// samples. After reset the button must first be seen released (debounced low)
// before any press is accepted, so a button held through reset is ignored.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   btn_i    raw asynchronous button
//   level_o  debounced level
//   rise_o   one-cycle pulse on each accepted rising edge
module btn_debounce
   import stage_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);

   localparam int unsigned CNT_W =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             armed_q, armed_d;
   logic             rise_q, rise_d;
   logic             target;

   // Until armed, count released samples; once armed, count samples that
   // disagree with the accepted level
   always_comb begin
      target  = armed_q ? ~level_q : 1'b0;
      cnt_d   = cnt_q;
      level_d = level_q;
      armed_d = armed_q;
      rise_d  = 1'b0;
      if (sync2_q == target) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (armed_q) begin
               level_d = target;
               rise_d  = target;
            end else begin
               armed_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         armed_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         armed_q <= armed_d;
         rise_q  <= rise_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/stage_sequencer.sv
// Top-level stage sequencer: start screen, timed transition slides and three
// games ending in the deco stage, held until reset. All outputs are Moore
// outputs registered one cycle after the FSM state register.
// Build macro: RETRY_SCREEN_EN selects the retry screen in game 3 when
// lives and level_completed are both zero; otherwise lives/level_completed
// are unused.
// Ports:
//   CLOCK            100 MHz system clock
//   reset            synchronous active-high reset
//   btnC             raw start button
//   completed1       game-1 done level
//   complete2        game-2 done level
//   completed3       game-3 done level
//   lives            game-3 lives remaining
//   level_completed  game-3 level count
//   state            stage code (0 idle/transition, 1..3 games, 8 deco)
//   disp_sel         OLED source select
//   seg_sel          7-segment owner
//   start_deco       deco enable level
module stage_sequencer
   import stage_pkg::*;
#(
   parameter int unsigned TRANS_CYCLES    = 300_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                CLOCK,
   input  logic                reset,
   input  logic                btnC,
   input  logic                completed1,
   input  logic                complete2,
   input  logic                completed3,
   input  logic [1:0]          lives,
   input  logic [1:0]          level_completed,
   output logic [STAGE_W-1:0]  state,
   output logic [DISP_W-1:0]   disp_sel,
   output logic [SEG_W-1:0]    seg_sel,
   output logic                start_deco
);

   localparam logic [TRANS_CNT_W-1:0] TRANS_LAST = TRANS_CNT_W'(TRANS_CYCLES - 1);

   fsm_e                   fsm_q, fsm_d;
   logic [TRANS_CNT_W-1:0] trans_cnt_q, trans_cnt_d;
   logic [STAGE_W-1:0]     stage_q;
   logic [DISP_W-1:0]      disp_q, disp_d;
   logic [SEG_W-1:0]       seg_q;
   logic                   deco_q;
   logic                   btn_level;
   logic                   btn_rise;
   logic                   trans_done;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk_i   (CLOCK),
      .rst_i   (reset),
      .btn_i   (btnC),
      .level_o (btn_level),
      .rise_o  (btn_rise)
   );

   assign trans_done = (trans_cnt_q == TRANS_LAST);

   // Next state; each stage only listens to its own completion input
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         ST_IDLE:   if (btn_rise)   fsm_d = ST_TRANS0;
         ST_TRANS0: if (trans_done) fsm_d = ST_GAME1;
         ST_GAME1:  if (completed1) fsm_d = ST_TRANS1;
         ST_TRANS1: if (trans_done) fsm_d = ST_GAME2;
         ST_GAME2:  if (complete2)  fsm_d = ST_GAME3;
         ST_GAME3:  if (completed3) fsm_d = ST_TRANS2;
         ST_TRANS2: if (trans_done) fsm_d = ST_DECO;
         ST_DECO:   fsm_d = ST_DECO;
         default:   fsm_d = ST_IDLE;
      endcase
   end

   // Slide timer: cleared on every state change, saturates instead of wrapping
   always_comb begin
      trans_cnt_d = trans_cnt_q;
      if (fsm_d != fsm_q) begin
         trans_cnt_d = '0;
      end else if (is_trans(fsm_q) && !trans_done) begin
         trans_cnt_d = trans_cnt_q + TRANS_CNT_W'(1);
      end
   end

   // OLED source, with optional retry screen override in game 3
   always_comb begin
      disp_d = disp_code(fsm_q);
`ifdef RETRY_SCREEN_EN
      if ((fsm_q == ST_GAME3) && (lives == 2'd0) && (level_completed == 2'd0)) begin
         disp_d = DISP_RETRY;
      end
`endif
   end

`ifndef RETRY_SCREEN_EN
   logic unused_game3_status;
   assign unused_game3_status = ^{lives, level_completed, btn_level};
`else
   logic unused_btn_level;
   assign unused_btn_level = btn_level;
`endif

   // State register plus Moore outputs derived from the registered state;
   // reset clears outputs directly so no intermediate code is emitted
   always_ff @(posedge CLOCK) begin
      if (reset) begin
         fsm_q       <= ST_IDLE;
         trans_cnt_q <= '0;
         stage_q     <= STAGE_IDLE;
         disp_q      <= DISP_START;
         seg_q       <= SEG_BLANK;
         deco_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         trans_cnt_q <= trans_cnt_d;
         stage_q     <= stage_code(fsm_q);
         disp_q      <= disp_d;
         seg_q       <= seg_code(fsm_q);
         deco_q      <= (fsm_q == ST_DECO);
      end
   end

   assign state      = stage_q;
   assign disp_sel   = disp_q;
   assign seg_sel    = seg_q;
   assign start_deco = deco_q;

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter TRANS_CYCLES, default 300_000_000, transition-slide hold time in CLOCK cycles.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, stable cycles required on btnC.
REQ-003 SHALL have port CLOCK  input  1  100 MHz system clock, the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btnC  input  1  raw asynchronous start button.
REQ-006 SHALL have port completed1  input  1  game-1 done level.
REQ-007 SHALL have port complete2  input  1  game-2 done level.
REQ-008 SHALL have port completed3  input  1  game-3 done level.
REQ-009 SHALL have port lives  input  2  game-3 lives remaining.
REQ-010 SHALL have port level_completed  input  2  game-3 level count.
REQ-011 SHALL have port state  output  4  stage code: 0 idle/transition, 1 game1, 2 game2, 3 game3, 8 deco.
REQ-012 SHALL have port disp_sel  output  4  OLED source select: 0 start, 1 trans0, 2 game1, 3 trans1, 4 game2, 5 game3, 6 retry, 7 trans2, 8 deco.
REQ-013 SHALL have port seg_sel  output  2  7-seg owner: 0 blank, 1 game2, 2 game3.
REQ-014 SHALL have port start_deco  output  1  deco enable level.

Function
REQ-015 SHALL implement FSM states IDLE, TRANS0, GAME1, TRANS1, GAME2, GAME3, TRANS2, DECO.
REQ-016 SHALL pass btnC through a 2-flop synchronizer, then accept a level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-017 SHALL move IDLE->TRANS0 on the debounced btnC rising edge; btnC SHALL be ignored in every other state.
REQ-018 SHALL, in each TRANSn, count 0..TRANS_CYCLES-1 and advance on the cycle the count equals TRANS_CYCLES-1: TRANS0->GAME1, TRANS1->GAME2, TRANS2->DECO.
REQ-019 SHALL clear the transition counter on every state entry; the counter SHALL be 32 bits and never wrap.
REQ-020 SHALL advance GAME1->TRANS1 on completed1, GAME2->GAME3 directly on complete2, GAME3->TRANS2 on completed3, each sampled high for one cycle.
REQ-021 SHALL ignore completion inputs belonging to any stage other than the current one; simultaneous completions SHALL act only on the current stage's input.
REQ-022 SHALL hold DECO until reset.
REQ-023 SHALL drive state, disp_sel, seg_sel, start_deco as registered Moore outputs, updating the cycle after the state register.
REQ-024 SHALL set seg_sel=1 only in GAME2, 2 only in GAME3, else 0; start_deco=1 only in DECO.

Reset
REQ-025 SHALL, on reset high at any CLOCK edge, go to IDLE with state=0, disp_sel=0, seg_sel=0, start_deco=0, counters and debouncer cleared, debounced level 0.
REQ-026 SHALL abort any in-progress transition or game on reset without emitting an intermediate stage code.
REQ-027 SHALL require btnC to be released and re-pressed after reset before leaving IDLE.

Configuration
REQ-028 SHALL, with RETRY_SCREEN_EN defined, output disp_sel=6 in GAME3 while lives==0 and level_completed==0, else 5.
REQ-029 SHALL, without RETRY_SCREEN_EN, output disp_sel=5 throughout GAME3 and leave lives/level_completed unused.

Structure
REQ-030 SHALL place state enum, stage codes and disp_sel/seg_sel codes in shared package stage_pkg.
REQ-031 SHALL implement synchronizer and debouncer as sub-module btn_debounce.

Verification (TRANS_CYCLES=10, DEBOUNCE_CYCLES=4)
REQ-032 SHALL cover: btnC high 6 cycles from IDLE -> disp_sel=1, then after 10 cycles state=1, disp_sel=2.
REQ-033 SHALL cover: btnC high 2 cycles (bounce) -> remains IDLE, disp_sel=0.
REQ-034 SHALL cover: complete2 and completed3 pulsed while in GAME1 -> no change; then completed1 -> disp_sel=3 for 10 cycles, then state=2, seg_sel=1.
REQ-035 SHALL cover: in GAME3 lives=0, level_completed=0 -> disp_sel=6 with macro, 5 without; lives=2 -> 5.
REQ-036 SHALL cover: completed3 in GAME3 -> disp_sel=7 for 10 cycles, then state=8, start_deco=1, seg_sel=0, stable 100 cycles.
REQ-037 SHALL cover: reset asserted at transition count 5 of TRANS1 -> next cycle all outputs 0; held btnC does not restart until released and re-pressed.
